// File: rtl/cam_capture_vga.sv
// cam_capture_vga: OV7670 RGB565 capture into an RGB444 frame buffer, shown top-left on a 640x480@60 VGA raster.
// Ports: clk/rst (async, active-high); VGA_Hsync_n/VGA_Vsync_n/VGA_R/G/B registered VGA outputs;
// data_mem registered frame-buffer read data; CAM_xclk (clk/4), CAM_pwdn (0), CAM_reset (active low) camera controls;
// CAM_pclk/CAM_vsync/CAM_href/CAM_px_data camera inputs, synchronised and sampled as data.
// Optional: define IMG_BORDER_EN for a white frame just right of and below the image.
module cam_capture_vga #(
  parameter int IMG_W = 160,
  parameter int IMG_H = 120,
  parameter int AW = 15,
  parameter int DW = 12
) (
  input  logic          clk,
  input  logic          rst,
  output logic          VGA_Hsync_n,
  output logic          VGA_Vsync_n,
  output logic [3:0]    VGA_R,
  output logic [3:0]    VGA_G,
  output logic [3:0]    VGA_B,
  output logic [DW-1:0] data_mem,
  output logic          CAM_xclk,
  output logic          CAM_pwdn,
  output logic          CAM_reset,
  input  logic          CAM_pclk,
  input  logic          CAM_vsync,
  input  logic          CAM_href,
  input  logic [7:0]    CAM_px_data
);
  localparam int N = IMG_W * IMG_H;
  localparam int IW = $clog2(N);
  localparam logic [9:0] WX = 10'(IMG_W);
  localparam logic [9:0] WY = 10'(IMG_H);
  logic [1:0] div;
  logic pe;
  logic [10:0] s1, s2;
  logic pclk_d, pedge;
  logic [AW-1:0] wr_addr;
  logic phase;
  logic [7:0] byte1;
  logic we;
  logic [IW-1:0] wa, ra;
  logic [DW-1:0] wd, ram_q;
  logic [DW-1:0] mem [N];
  logic [9:0] h, v;
  logic hs_c, vs_c, win_c, bor_c;
  logic d_hs, d_vs, d_win, d_bor;
  logic unused_bits;
  assign pe = &div;
  assign CAM_xclk = div[1];
  assign CAM_pwdn = 1'b0;
  // s2 = {pclk, vsync, href, data[7:0]}; a rising pclk sample marks a new byte
  assign pedge = s2[10] & ~pclk_d;
  assign unused_bits = ^{byte1[3], s2[6:5], s2[0]};
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      div <= '0;
      CAM_reset <= 1'b0;
    end else begin
      div <= div + 2'd1;
      CAM_reset <= 1'b1;
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
      pclk_d <= 1'b0;
      wr_addr <= '0;
      phase <= 1'b0;
      byte1 <= '0;
      we <= 1'b0;
      wa <= '0;
      wd <= '0;
    end else begin
      s1 <= {CAM_pclk, CAM_vsync, CAM_href, CAM_px_data};
      s2 <= s1;
      pclk_d <= s2[10];
      we <= 1'b0;
      if (pedge) begin
        if (s2[9]) begin
          wr_addr <= '0;
          phase <= 1'b0;
        end else if (s2[8]) begin
          phase <= ~phase;
          if (!phase) byte1 <= s2[7:0];
          // wr_addr parks at N once the frame is full; writes resume after the next vsync
          else if (wr_addr != AW'(N)) begin
            we <= 1'b1;
            wa <= IW'(wr_addr);
            wd <= {byte1[7:4], byte1[2:0], s2[7], s2[4:1]};
            wr_addr <= wr_addr + 1'b1;
          end
        end else phase <= 1'b0;
      end
    end
  // read-before-write on a shared address falls out of the non-blocking read
  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
    ram_q <= mem[ra];
  end
  always_comb begin
    hs_c = !(h >= 10'd656 && h < 10'd752);
    vs_c = !(v >= 10'd490 && v < 10'd492);
    win_c = h < WX && v < WY;
`ifdef IMG_BORDER_EN
    bor_c = (h == WX && v <= WY) || (v == WY && h <= WX);
`else
    bor_c = 1'b0;
`endif
  end
  // stage 1 issues the read and delays the flags; stage 2 presents RAM data one pixel later
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      h <= '0;
      v <= '0;
      ra <= '0;
      d_hs <= 1'b1;
      d_vs <= 1'b1;
      d_win <= 1'b0;
      d_bor <= 1'b0;
      VGA_Hsync_n <= 1'b1;
      VGA_Vsync_n <= 1'b1;
      {VGA_R, VGA_G, VGA_B} <= '0;
      data_mem <= '0;
    end else if (pe) begin
      h <= h == 10'd799 ? '0 : h + 10'd1;
      v <= h != 10'd799 ? v : v == 10'd524 ? '0 : v + 10'd1;
      ra <= win_c ? IW'(32'(v) * IMG_W + 32'(h)) : '0;
      d_hs <= hs_c;
      d_vs <= vs_c;
      d_win <= win_c;
      d_bor <= bor_c;
      VGA_Hsync_n <= d_hs;
      VGA_Vsync_n <= d_vs;
      data_mem <= ram_q;
      {VGA_R, VGA_G, VGA_B} <= d_win ? ram_q : d_bor ? '1 : '0;
    end
endmodule

// File: tb/tb_cam_capture_vga.sv
// tb_cam_capture_vga: random/directed capture frames checked through the VGA raster against a frame-buffer model.
module tb_cam_capture_vga;
  localparam int W = 16, H = 4, N = W * H;
  logic clk = 0, rst = 1;
  logic hs_n, vs_n, xclk, pwdn, cam_rst_n;
  logic [3:0] r, g, b;
  logic [11:0] dm;
  logic pclk = 0, vsync = 0, href = 0;
  logic [7:0] px = 0;
  int cyc, vectors = 0, miscompares = 0, pix, idx, ph, hlow;
  logic [7:0] b1;
  logic [11:0] fb [N];
  logic [7:0] pat [4] = '{8'hF8, 8'h1F, 8'h07, 8'hE0};

  cam_capture_vga #(.IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst(rst), .VGA_Hsync_n(hs_n), .VGA_Vsync_n(vs_n),
    .VGA_R(r), .VGA_G(g), .VGA_B(b), .data_mem(dm),
    .CAM_xclk(xclk), .CAM_pwdn(pwdn), .CAM_reset(cam_rst_n),
    .CAM_pclk(pclk), .CAM_vsync(vsync), .CAM_href(href), .CAM_px_data(px));

  always #5 clk = ~clk;
  always @(posedge clk or posedge rst) if (rst) cyc <= 0; else cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s (pixel %0d): got %0h, expected %0h", tag, pix, obs, exp);
    end
  endtask

  function automatic logic [11:0] conv(input logic [7:0] a, input logic [7:0] c);
    int ra, ga, ba;
    ra = int'(a) / 16;
    ga = (int'(a) % 8) * 2 + int'(c) / 128;
    ba = (int'(c) / 2) % 16;
    return 12'(ra * 256 + ga * 16 + ba);
  endfunction

  task automatic put(input logic [7:0] d);
    @(negedge clk) begin px = d; pclk = 0; end
    @(negedge clk);
    @(negedge clk) pclk = 1;
    @(negedge clk);
    if (vsync) begin idx = 0; ph = 0; end
    else if (href) begin
      if (ph == 0) begin b1 = d; ph = 1; end
      else begin
        if (idx < N) begin fb[idx] = conv(b1, d); idx++; end
        ph = 0;
      end
    end else ph = 0;
  endtask

  task automatic vsync_pulse();
    @(negedge clk) vsync = 1;
    repeat (4) put(8'h00);
    @(negedge clk) vsync = 0;
  endtask

  task automatic line(input int fixed, input bit order);
    logic [7:0] d;
    @(negedge clk) href = 1;
    for (int i = 0; i < 2 * W; i++) begin
      d = (order && i < 4) ? pat[i] : (fixed < 0) ? 8'($urandom) : 8'(fixed);
      put(d);
    end
    @(negedge clk) href = 0;
    repeat (2) put(8'h00);
  endtask

  task automatic do_reset();
    @(negedge clk) begin rst = 1; pclk = 0; href = 0; vsync = 0; end
    #1;
    pix = -1;
    chk("rst_hsync", hs_n, 1);
    chk("rst_vsync", vs_n, 1);
    chk("rst_rgb", {r, g, b}, 0);
    chk("rst_data_mem", dm, 0);
    chk("rst_cam_reset", cam_rst_n, 0);
    chk("rst_xclk", xclk, 0);
    chk("rst_pwdn", pwdn, 0);
    repeat (20) @(negedge clk);
    rst = 0;
    idx = 0;
    ph = 0;
  endtask

  task automatic watch(input int n);
    int h, v;
    logic [11:0] e;
    hlow = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      pix = cyc / 4 - 2;
      chk("xclk", xclk, (cyc % 4) >= 2);
      chk("cam_reset", cam_rst_n, 1);
      chk("pwdn", pwdn, 0);
      if (pix < 0) begin
        chk("hsync_pre", hs_n, 1);
        chk("rgb_pre", {r, g, b}, 0);
      end else begin
        h = pix % 800;
        v = (pix / 800) % 525;
        e = 12'h000;
        if (h < W && v < H) e = fb[v * W + h];
`ifdef IMG_BORDER_EN
        else if ((h == W && v <= H) || (v == H && h <= W)) e = 12'hFFF;
`endif
        chk("hsync", hs_n, !(h >= 656 && h < 752));
        chk("vsync", vs_n, !(v >= 490 && v < 492));
        chk("rgb", {r, g, b}, e);
        if (h < W && v < H) chk("data_mem", dm, fb[v * W + h]);
        if (pix >= 800 && pix < 1600 && !hs_n) hlow++;
      end
    end
    chk("hsync_low_clocks_per_line", hlow, 96 * 4);
  endtask

  initial begin
    idx = 0;
    ph = 0;
    pix = -1;
    repeat (20) @(negedge clk);
    chk("init_hsync", hs_n, 1);
    chk("init_rgb", {r, g, b}, 0);
    chk("init_cam_reset", cam_rst_n, 0);
    chk("init_xclk", xclk, 0);
    rst = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("rel_cam_reset", cam_rst_n, 1);
      chk("rel_xclk", xclk, (cyc % 4) >= 2);
    end
    vsync_pulse();
    for (int l = 0; l < H; l++) line(8'h0F, 0);
    repeat (10) @(negedge clk);
    do_reset();
    watch(13200);
    vsync_pulse();
    line(-1, 1);
    for (int l = 0; l < H; l++) line(-1, 0);
    repeat (10) @(negedge clk);
    do_reset();
    watch(13200);
    vsync_pulse();
    line(-1, 0);
    @(negedge clk) href = 1;
    repeat (3) put(8'($urandom));
    repeat (10) @(negedge clk);
    do_reset();
    line(-1, 0);
    repeat (10) @(negedge clk);
    do_reset();
    watch(13200);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
